// File: rtl/nios2_debug_ocimem_arbiter_if.sv
// Bus bundle for the OCI RAM arbiter: the CPU's Avalon debug-memory slave port
// and the single-port OCI RAM port.
interface nios2_debug_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  // Avalon: a request (avs_read | avs_write) with its address/data is held
  // until a cycle in which avs_waitrequest is low; that cycle completes the
  // transfer and, for reads, avs_readdata is valid in that same cycle.
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic [31:0]       ram_rdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  ram_rdata,
    output avs_readdata, avs_waitrequest,
    output ram_addr, ram_wren, ram_wdata, ram_be
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output ram_rdata,
    input  avs_readdata, avs_waitrequest,
    input  ram_addr, ram_wren, ram_wdata, ram_be
  );
endinterface

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between the JTAG debug
// command path (one-deep pending slot) and the CPU's Avalon debug slave.
module nios2_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  jtag_overrun,
  nios2_debug_ocimem_arbiter_if.slave bus,
  output logic [2:0]            dbg_state,
  output logic [ADDR_W-1:0]     dbg_jtag_addr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_JTAG_ACC = 3'd1,
    S_JTAG_RD  = 3'd2,
    S_CPU_ACC  = 3'd3,
    S_CPU_RD   = 3'd4
  } state_t;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;
  typedef enum logic {GNT_CPU = 1'b0, GNT_JTAG = 1'b1} gnt_t;

  state_t              r_state;
  state_t              w_next_state;
  gnt_t                r_last_grant;
  logic                r_pend;
  op_t                 r_pend_op;
  logic [DATA_W-1:0]   r_pend_data;
  logic [ADDR_W-1:0]   r_jtag_addr;
  logic [DATA_W-1:0]   r_mon_dreg;
  logic                r_monitor_ready;
  logic                r_jtag_overrun;
  logic [DATA_W-1:0]   r_avs_readdata;

  logic                w_cpu_req;
  logic                w_cpu_done;
  logic                w_jtag_done;
  logic                w_strobe;
  logic [ADDR_W-1:0]   w_jdo_addr;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_ram_wren;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [3:0]          w_ram_be;
  logic                w_unused_jdo;

  assign w_cpu_req    = bus.avs_read | bus.avs_write;
  assign w_strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_jdo_addr   = jdo[17 +: ADDR_W];
  assign w_unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

  always_comb begin
    w_next_state = r_state;
    w_ram_addr   = '0;
    w_ram_wren   = 1'b0;
    w_ram_wdata  = '0;
    w_ram_be     = 4'hF;
    w_cpu_done   = 1'b0;
    w_jtag_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On contention the requester that was not granted last wins.
        if (r_pend && (!w_cpu_req || r_last_grant == GNT_CPU))
          w_next_state = S_JTAG_ACC;
        else if (w_cpu_req)
          w_next_state = S_CPU_ACC;
      end
      S_JTAG_ACC: begin
        w_ram_addr  = r_jtag_addr;
        w_ram_wdata = r_pend_data;
        if (r_pend_op == OP_WR) begin
          w_ram_wren   = 1'b1;
          w_jtag_done  = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_JTAG_RD;
        end
      end
      S_JTAG_RD: begin
        w_jtag_done  = 1'b1;
        w_next_state = S_IDLE;
      end
      S_CPU_ACC: begin
        w_ram_addr  = bus.avs_address;
        w_ram_be    = bus.avs_byteenable;
        w_ram_wdata = bus.avs_writedata;
        if (bus.avs_write) begin
          w_ram_wren   = 1'b1;
          w_cpu_done   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_CPU_RD;
        end
      end
      S_CPU_RD: begin
        w_cpu_done   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // Reset aborts an in-flight access in the very cycle it is sampled.
    if (reset) begin
      w_next_state = S_IDLE;
      w_ram_addr   = '0;
      w_ram_wren   = 1'b0;
      w_cpu_done   = 1'b0;
      w_jtag_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_last_grant    <= GNT_CPU;
      r_pend          <= 1'b0;
      r_pend_op       <= OP_RD;
      r_pend_data     <= '0;
      r_jtag_addr     <= '0;
      r_mon_dreg      <= '0;
      r_monitor_ready <= 1'b0;
      r_jtag_overrun  <= 1'b0;
      r_avs_readdata  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_next_state == S_JTAG_ACC)
        r_last_grant <= GNT_JTAG;
      else if (r_state == S_IDLE && w_next_state == S_CPU_ACC)
        r_last_grant <= GNT_CPU;

      if (r_state == S_CPU_RD)
        r_avs_readdata <= bus.ram_rdata;

      if (w_jtag_done) begin
        r_pend          <= 1'b0;
        r_jtag_addr     <= r_jtag_addr + ADDR_W'(1);
        r_monitor_ready <= 1'b1;
        if (r_state == S_JTAG_RD)
          r_mon_dreg <= bus.ram_rdata;
      end

      // Strobes only land when the slot is empty, so they never collide with
      // the completion updates above.
      if (w_strobe) begin
        if (r_pend) begin
          r_jtag_overrun <= 1'b1;
        end else begin
          r_monitor_ready <= 1'b0;
          if (take_action_ocimem_a) begin
            r_jtag_addr <= w_jdo_addr;
            if (jdo[34]) begin
              r_pend    <= 1'b1;
              r_pend_op <= OP_RD;
            end
          end else if (take_action_ocimem_b) begin
            r_pend      <= 1'b1;
            r_pend_op   <= OP_WR;
            r_pend_data <= jdo[3 +: DATA_W];
          end else begin
            r_pend    <= 1'b1;
            r_pend_op <= OP_RD;
          end
        end
      end
    end
  end

  assign bus.ram_addr        = w_ram_addr;
  assign bus.ram_wren        = w_ram_wren;
  assign bus.ram_wdata       = w_ram_wdata;
  assign bus.ram_be          = w_ram_be;
  assign bus.avs_waitrequest = w_cpu_req & ~w_cpu_done;
  assign bus.avs_readdata    = reset ? '0 :
                               (r_state == S_CPU_RD) ? bus.ram_rdata : r_avs_readdata;

  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_monitor_ready;
  assign jtag_overrun  = r_jtag_overrun;
  assign dbg_state     = r_state;
  assign dbg_jtag_addr = r_jtag_addr;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter: drivers push expected RAM writes,
// CPU read completions and JTAG completions; a monitor pops and compares.
module tb_nios2_debug_ocimem_arbiter;
  localparam int W = 48;  // {tag[3:0], be[3:0], addr[7:0], data[31:0]}

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_jtag_addr;

  nios2_debug_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

  nios2_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun),
    .bus                     (bus),
    .dbg_state               (dbg_state),
    .dbg_jtag_addr           (dbg_jtag_addr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model: 1-cycle read latency, byte enables ----------------
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= {8'hC0, 8'(i), ~8'(i), 8'(i)};
      mem_loaded <= 1'b1;
    end else if (bus.ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_be[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected event %0h with empty expected queue", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  logic mr_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.ram_wren)
          sb_check("ram_write", {4'd1, bus.ram_be, bus.ram_addr, bus.ram_wdata});
        if (bus.avs_read && !bus.avs_write && !bus.avs_waitrequest)
          sb_check("cpu_read", {4'd2, 4'd0, bus.avs_address, bus.avs_readdata});
        if (monitor_ready && !mr_prev)
          sb_check("jtag_done", {4'd3, 4'd0, dbg_jtag_addr, MonDReg});
      end
      mr_prev = monitor_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input int exp_lat);
    int  lat;
    logic done;
    if (wr) exp_q.push_back({4'd1, be, addr, data});
    else    exp_q.push_back({4'd2, 4'd0, addr, data});
    bus.avs_address    = addr;
    bus.avs_writedata  = wr ? data : 32'h0;
    bus.avs_byteenable = be;
    bus.avs_write      = wr;
    bus.avs_read       = ~wr;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!bus.avs_waitrequest) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(wr ? "cpu_wr_latency" : "cpu_rd_latency", 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  task automatic jtag_pulse(input int which, input logic [37:0] j);
    jdo                     = j;
    take_action_ocimem_a    = (which == 0);
    take_action_ocimem_b    = (which == 1);
    take_no_action_ocimem_a = (which == 2);
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd);
    jtag_pulse(0, {3'b0, rd, 9'b0, addr, 17'b0});
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jtag_pulse(1, {3'b0, data, 3'b0});
  endtask

  task automatic jtag_rd();
    jtag_pulse(2, 38'h0);
  endtask

  task automatic expect_jtag_done(input logic [7:0] addr_after, input logic [31:0] mon);
    exp_q.push_back({4'd3, 4'd0, addr_after, mon});
  endtask

  task automatic expect_jtag_write(input logic [7:0] addr, input logic [31:0] data);
    exp_q.push_back({4'd1, 4'hF, addr, data});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_byteenable = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mondreg", 64'(MonDReg), 64'h0);
    check("rst_monitor_ready", 64'(monitor_ready), 64'h0);
    check("rst_overrun", 64'(jtag_overrun), 64'h0);
    check("rst_readdata", 64'(bus.avs_readdata), 64'h0);
    check("rst_ram_wren", 64'(bus.ram_wren), 64'h0);
    check("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    check("rst_jtag_addr", 64'(dbg_jtag_addr), 64'h0);
    check("rst_waitrequest", 64'(bus.avs_waitrequest), 64'h0);
    @(posedge clk);
    #1;

    // CPU write/read, including a partial byte-enable write.
    cpu_access(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2);
    cpu_access(1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 3);
    cpu_access(1'b1, 8'h11, 32'hAAAABBBB, 4'h3, 2);
    cpu_access(1'b0, 8'h11, 32'hC011BBBB, 4'hF, 3);

    // Collision with last grant = CPU: JTAG read of addr 0 goes first.
    jtag_rd();
    expect_jtag_done(8'h01, 32'hC000FF00);
    cpu_access(1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 6);
    idle(2);

    // JTAG address load, write, then address load with read.
    jtag_a(8'h20, 1'b0);
    jtag_b(32'h12345678);
    expect_jtag_write(8'h20, 32'h12345678);
    expect_jtag_done(8'h21, 32'hC000FF00);
    idle(6);
    check("monitor_ready_after_wr", 64'(monitor_ready), 64'h1);
    jtag_a(8'h20, 1'b1);
    expect_jtag_done(8'h21, 32'h12345678);
    idle(6);

    // Collision with last grant = JTAG: CPU goes first, then JTAG read of 0x21.
    jtag_rd();
    cpu_access(1'b0, 8'h11, 32'hC011BBBB, 4'hF, 3);
    expect_jtag_done(8'h22, 32'hC021DE21);
    idle(6);
    check("overrun_still_clear", 64'(jtag_overrun), 64'h0);

    // Second ocimem_b while the first waits behind a CPU read is dropped.
    jtag_a(8'h40, 1'b0);
    fork
      cpu_access(1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 3);
      begin
        @(posedge clk);
        #1;
        jtag_b(32'h11110000);
        expect_jtag_write(8'h40, 32'h11110000);
        expect_jtag_done(8'h41, 32'hC021DE21);
        jtag_b(32'h22220000);
      end
    join
    idle(6);
    check("overrun_set", 64'(jtag_overrun), 64'h1);

    // Address wrap on post-increment.
    jtag_a(8'hFF, 1'b0);
    jtag_rd();
    expect_jtag_done(8'h00, 32'hC0FF00FF);
    idle(6);

    // Reset sampled while a CPU write is in CPU_ACC: the write must not land.
    bus.avs_address    = 8'h30;
    bus.avs_writedata  = 32'h5555AAAA;
    bus.avs_byteenable = 4'hF;
    bus.avs_write      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ram_wren", 64'(bus.ram_wren), 64'h0);
    check("midrst_waitrequest", 64'(bus.avs_waitrequest), 64'h1);
    check("midrst_ram_addr", 64'(bus.ram_addr), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.avs_write = 1'b0;
    @(negedge clk);
    check("postrst_mondreg", 64'(MonDReg), 64'h0);
    check("postrst_monitor_ready", 64'(monitor_ready), 64'h0);
    check("postrst_overrun", 64'(jtag_overrun), 64'h0);
    check("postrst_state", 64'(dbg_state), 64'h0);
    check("postrst_readdata", 64'(bus.avs_readdata), 64'h0);
    check("postrst_waitrequest", 64'(bus.avs_waitrequest), 64'h0);
    check("postrst_mem_0x30", 64'(mem[8'h30]), 64'hC030CF30);
    idle(4);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios2_debug_ocimem_arbiter.md
Name: nios2_debug_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug memory (OCI RAM, 2^ADDR_W × 32) between two requesters: the JTAG debug-slave command path (jdo plus the ocimem take_action strobes, clk domain) and the CPU's Avalon debug memory slave.
- Sequences each access, returns read data to the JTAG monitor register (MonDReg) or to the Avalon readdata, and applies round-robin fairness.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, data width; fixed at 32, jdo field positions depend on it

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG data-out word, valid with strobes
take_action_ocimem_a  in  1  load JTAG address; optional read
take_no_action_ocimem_a  in  1  JTAG read at address, post-increment
take_action_ocimem_b  in  1  JTAG write at address, post-increment
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  JTAG access complete (sticky)
jtag_overrun  out  1  sticky: JTAG strobe dropped
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_wdata  out  32  RAM write data
ram_be  out  4  RAM byte enables
ram_rdata  in  32  RAM read data, 1-cycle latency

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset values:
  - MonDReg = 0, monitor_ready = 0, jtag_overrun = 0, avs_readdata = 0.
  - ram_wren = 0, ram_addr = 0, jtag_addr = 0.
  - JTAG pending = 0, last_grant = CPU, state IDLE.
  - A reset mid-access aborts the access; no write completes after reset is sampled.
- JTAG command decode (one-deep pending slot, pend_op ∈ {RD, WR}):
  - ocimem_a: jtag_addr <= jdo[17+ADDR_W-1:17]. If jdo[34] = 1, queue RD at the new address. Clears monitor_ready.
  - no_action_ocimem_a: queue RD at jtag_addr. Clears monitor_ready.
  - ocimem_b: queue WR of jdo[34:3] at jtag_addr, byte enables 4'hF. Clears monitor_ready.
  - A strobe arriving while the slot is full is dropped; jtag_overrun <= 1. It clears only on reset.
  - Strobes are mutually exclusive. If several are asserted together, priority is ocimem_a > ocimem_b > no_action.
- FSM states: IDLE, JTAG_ACC, JTAG_RD, CPU_ACC, CPU_RD.
  - IDLE:
    - Only JTAG pending -> JTAG_ACC.
    - Only CPU request (avs_read | avs_write) -> CPU_ACC.
    - Both -> grant the requester not equal to last_grant.
    - Update last_grant on every grant.
  - JTAG_ACC: drive ram_addr = jtag_addr.
    - WR: ram_wren = 1. Next cycle: jtag_addr += 1 (wraps mod 2^ADDR_W), clear pending, monitor_ready <= 1, -> IDLE.
    - RD: -> JTAG_RD.
  - JTAG_RD: MonDReg <= ram_rdata, jtag_addr += 1, clear pending, monitor_ready <= 1, -> IDLE.
  - CPU_ACC: drive ram_addr = avs_address and ram_be = avs_byteenable.
    - Write: ram_wren = 1, avs_waitrequest = 0 this cycle, -> IDLE.
    - Read: -> CPU_RD.
  - CPU_RD: avs_readdata = ram_rdata (registered path), avs_waitrequest = 0, -> IDLE.
- avs_waitrequest = (avs_read | avs_write) & ~(completion cycle). It is combinational, low when there is no request.
- CPU latency with no contention:
  - Write: 2 cycles, request to waitrequest low.
  - Read: 3 cycles.
- JTAG accesses arriving during a CPU access wait in the slot. Neither requester waits more than one foreign access.
- avs_read and avs_write asserted together: write wins.

Test Plan:
- Reset, then CPU write addr 0x10 data 0xDEADBEEF be 4'hF -> ram_wren 1 cycle at ram_addr 0x10, waitrequest low on the 2nd cycle. CPU read of 0x10 -> readdata 0xDEADBEEF on the 3rd cycle.
- ocimem_a with addr 0x20 and jdo[34] = 0, then ocimem_b with data 0x12345678 -> RAM[0x20] written, jtag_addr = 0x21, monitor_ready = 1. ocimem_a with addr 0x20 and jdo[34] = 1 -> MonDReg = 0x12345678, jtag_addr = 0x21.
- JTAG read pending and CPU read asserted in the same cycle after reset (last_grant = CPU) -> JTAG served first, CPU served next. Repeating the collision -> CPU served first.
- Two back-to-back ocimem_b strobes while the first is stalled by a CPU access -> second dropped, jtag_overrun = 1, only the first write lands.
- jtag_addr = 2^ADDR_W-1 (0xFF), no_action read -> jtag_addr wraps to 0x00.
- Reset asserted during CPU_ACC write -> ram_wren = 0 in the reset cycle, all outputs at reset values, waitrequest follows the request.
